// File: rtl/mfb_merger_sched.sv
// -----------------------------------------------------------------------------
// mfb_merger_sched
// Packet-level round-robin scheduler for the MVB+MFB merger datapath. It picks
// which input may push its next header (MVB item) and, if the header carries
// one, its payload (MFB frame) to TX. A grant is held for the whole packet, from
// header accept to payload EOF, so frames from different inputs never
// interleave. Consecutive grants are always separated by one idle cycle, and
// arbitration happens in that idle cycle.
//
// Optional feature: define MFB_MERGER_SCHED_BURST_EN to let one input keep
// priority for up to BURST_MAX consecutive packets.
//
// Parameters:
//   INPUTS        number of merged input streams (>=1)
//   PAYLOAD_MASK  bit i set: input i may carry an MFB payload
//   BURST_MAX     max consecutive packets per input (burst build only, >=1)
//
// Ports:
//   CLK           clock
//   RESET         synchronous, active-high reset
//   RX_REQ        per input: valid header at queue head
//   RX_PAYLOAD    per input: head header has a payload (valid with RX_REQ)
//   HDR_ACCEPT    granted header transferred to TX this cycle
//   PLD_EOF       granted payload EOF transferred to TX this cycle
//   GRANT_VLD     a grant is active
//   GRANT_SEL     index of the granted input
//   GRANT_ONEHOT  one-hot GRANT_SEL, all-zero when GRANT_VLD is low
//   GRANT_PLD     granted packet is in its payload phase
//   PKT_DONE      one-cycle pulse: granted packet fully transferred
// -----------------------------------------------------------------------------
module mfb_merger_sched #(
    parameter int                INPUTS       = 2,
    parameter logic [INPUTS-1:0] PAYLOAD_MASK = '1,
    parameter int                BURST_MAX    = 4
) (
    input  logic                                          CLK,
    input  logic                                          RESET,
    input  logic [INPUTS-1:0]                             RX_REQ,
    input  logic [INPUTS-1:0]                             RX_PAYLOAD,
    input  logic                                          HDR_ACCEPT,
    input  logic                                          PLD_EOF,
    output logic                                          GRANT_VLD,
    output logic [((INPUTS > 1) ? $clog2(INPUTS) : 1)-1:0] GRANT_SEL,
    output logic [INPUTS-1:0]                             GRANT_ONEHOT,
    output logic                                          GRANT_PLD,
    output logic                                          PKT_DONE
);

    localparam int SEL_W = (INPUTS > 1) ? $clog2(INPUTS) : 1;
    localparam int BC_W  = $clog2(BURST_MAX) + 1;

    // A non-positive burst limit is a configuration error; this block only
    // exists so such a build is easy to spot in the elaborated hierarchy.
    if (BURST_MAX < 1) begin : g_burst_max_invalid
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_PLD  = 2'd2
    } state_t;

    state_t             state_r;
    logic [SEL_W-1:0]   sel_r;
    logic [SEL_W-1:0]   ptr_r;
    logic               grant_vld_r;
    logic               grant_pld_r;
    logic               pkt_done_r;
    logic [INPUTS-1:0]  onehot_r;
`ifdef MFB_MERGER_SCHED_BURST_EN
    logic [BC_W-1:0]    bc_r;
`endif

    logic [SEL_W-1:0]   arb_idx_s;
    logic [SEL_W-1:0]   arb_cand_s;
    logic               arb_found_s;
    logic               has_pld_s;
    logic               done_s;

    // Index after v, wrapping from INPUTS-1 back to 0 (constant 0 when INPUTS=1).
    function automatic logic [SEL_W-1:0] inc_wrap(input logic [SEL_W-1:0] v);
        if (v == SEL_W'(INPUTS - 1)) begin
            return {SEL_W{1'b0}};
        end else begin
            return v + SEL_W'(1);
        end
    endfunction

    // One-hot decode of an input index.
    function automatic logic [INPUTS-1:0] to_onehot(input logic [SEL_W-1:0] idx);
        logic [INPUTS-1:0] oh;
        oh = {INPUTS{1'b0}};
        for (int i = 0; i < INPUTS; i++) begin
            oh[i] = (idx == SEL_W'(i));
        end
        return oh;
    endfunction

    // Round-robin search: first requester starting at ptr_r, wrapping around.
    always_comb begin
        arb_found_s = 1'b0;
        arb_idx_s   = {SEL_W{1'b0}};
        arb_cand_s  = ptr_r;
        for (int k = 0; k < INPUTS; k++) begin
            if (!arb_found_s && RX_REQ[arb_cand_s]) begin
                arb_found_s = 1'b1;
                arb_idx_s   = arb_cand_s;
            end else begin
                arb_found_s = arb_found_s;
            end
            arb_cand_s = inc_wrap(arb_cand_s);
        end
    end

    // Payload presence is qualified by the static per-input capability mask.
    assign has_pld_s = RX_PAYLOAD[sel_r] & PAYLOAD_MASK[sel_r];

    // Packet completion: header-only accept, accept with same-cycle EOF, or EOF in payload phase.
    always_comb begin
        done_s = 1'b0;
        case (state_r)
            ST_HDR: begin
                if (HDR_ACCEPT && (!has_pld_s || PLD_EOF)) begin
                    done_s = 1'b1;
                end else begin
                    done_s = 1'b0;
                end
            end
            ST_PLD:  done_s = PLD_EOF;
            default: done_s = 1'b0;
        endcase
    end

    // Scheduler FSM with registered grant outputs and round-robin pointer.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r     <= ST_IDLE;
            sel_r       <= {SEL_W{1'b0}};
            ptr_r       <= {SEL_W{1'b0}};
            grant_vld_r <= 1'b0;
            grant_pld_r <= 1'b0;
            pkt_done_r  <= 1'b0;
            onehot_r    <= {INPUTS{1'b0}};
`ifdef MFB_MERGER_SCHED_BURST_EN
            bc_r        <= {BC_W{1'b0}};
`endif
        end else begin
            pkt_done_r <= 1'b0;
            if (done_s) begin
                // Release the grant; the following cycle is the arbitration bubble.
                state_r     <= ST_IDLE;
                grant_vld_r <= 1'b0;
                grant_pld_r <= 1'b0;
                pkt_done_r  <= 1'b1;
                onehot_r    <= {INPUTS{1'b0}};
`ifdef MFB_MERGER_SCHED_BURST_EN
                if ((bc_r + BC_W'(1)) < BC_W'(BURST_MAX)) begin
                    ptr_r <= sel_r;
                    bc_r  <= bc_r + BC_W'(1);
                end else begin
                    ptr_r <= inc_wrap(sel_r);
                    bc_r  <= {BC_W{1'b0}};
                end
`else
                ptr_r <= inc_wrap(sel_r);
`endif
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (arb_found_s) begin
                            state_r     <= ST_HDR;
                            sel_r       <= arb_idx_s;
                            grant_vld_r <= 1'b1;
                            onehot_r    <= to_onehot(arb_idx_s);
`ifdef MFB_MERGER_SCHED_BURST_EN
                            // A different winner starts a fresh burst.
                            if (arb_idx_s != sel_r) begin
                                bc_r <= {BC_W{1'b0}};
                            end else begin
                                bc_r <= bc_r;
                            end
`endif
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_HDR: begin
                        // Accept without completion means a payload follows.
                        if (HDR_ACCEPT) begin
                            state_r     <= ST_PLD;
                            grant_pld_r <= 1'b1;
                        end else begin
                            state_r <= ST_HDR;
                        end
                    end
                    ST_PLD: begin
                        state_r <= ST_PLD;
                    end
                    default: begin
                        state_r     <= ST_IDLE;
                        grant_vld_r <= 1'b0;
                        grant_pld_r <= 1'b0;
                        onehot_r    <= {INPUTS{1'b0}};
                    end
                endcase
            end
        end
    end

    assign GRANT_VLD    = grant_vld_r;
    assign GRANT_SEL    = sel_r;
    assign GRANT_ONEHOT = onehot_r;
    assign GRANT_PLD    = grant_pld_r;
    assign PKT_DONE     = pkt_done_r;

endmodule
